// File: rtl/mem_load_pkg.sv
// Shared encodings for the MEM-stage load unit: load types, FSM states and
// the alignment rule applied before a read is issued.
package mem_load_pkg;

  // LoadType encodings from the Exec/Mem register; 101-111 behave as LW.
  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Byte loads are always aligned; halfwords need bit 0 clear; words need both bits clear.
  function automatic logic misaligned(input logic [2:0] lt, input logic [1:0] off);
    logic bad;
    case (lt)
      LT_LB, LT_LBU:  bad = 1'b0;
      LT_LH, LT_LHU:  bad = off[0];
      default:        bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_load_unit_extract.sv
// Purely combinational lane select and sign/zero extension of a memory word.
module load_extract
  import mem_load_pkg::*;
(
  input  logic [31:0] dm_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = dm_rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  // Pick the addressed lane(s) and extend according to the load type.
  always_comb begin
    data = dm_rdata;
    case (load_type)
      LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  data = {24'h0, byte_sel};
      LT_LH:   data = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  data = {16'h0, half_sel};
      default: data = dm_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_load_unit.sv
// MEM-stage load controller: issues a req/ack read to the multi-cycle data
// memory, stalls the pipeline while it is outstanding, and registers the
// extracted load result. Misaligned loads and timeouts raise one-cycle pulses.
module mem_stage_load_unit
  import mem_load_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic [2:0]  LoadType,
  input  logic [31:0] Addr,
  output logic        dm_req,
  output logic [29:0] dm_addr,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] read_data,
  output logic        Stall,
  output logic        AddrErr,
  output logic        BusErr
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t         state_reg, state_next;
  logic           req_reg, req_next;
  logic [29:0]    addr_reg, addr_next;
  logic [31:0]    data_reg, data_next;
  logic           aerr_reg, aerr_next;
  logic           berr_reg, berr_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [1:0]     off_reg, off_next;
  logic [2:0]     lt_reg, lt_next;
  logic [31:0]    ext_data;
  logic           stall_c;

  load_extract u_extract (
    .dm_rdata  (dm_rdata),
    .addr_lo   (off_reg),
    .load_type (lt_reg),
    .data      (ext_data)
  );

  // Next-state and next-register values; error pulses default low so they last one cycle.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    aerr_next  = 1'b0;
    berr_next  = 1'b0;
    cnt_next   = cnt_reg;
    off_next   = off_reg;
    lt_next    = lt_reg;
    stall_c    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (MemRead) begin
          if (misaligned(LoadType, Addr[1:0])) begin
            aerr_next = 1'b1;
          end else begin
            stall_c    = 1'b1;
            off_next   = Addr[1:0];
            lt_next    = LoadType;
            addr_next  = Addr[31:2];
            req_next   = 1'b1;
            cnt_next   = '0;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        // An ack in the timeout cycle still delivers data.
        if (dm_ack) begin
          data_next  = ext_data;
          req_next   = 1'b0;
          state_next = S_DONE;
        end else if (cnt_reg == CNT_LAST) begin
          data_next  = 32'h0;
          berr_next  = 1'b1;
          req_next   = 1'b0;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        // DONE: pipeline advances this cycle, so return to IDLE unconditionally.
        state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      req_reg   <= 1'b0;
      addr_reg  <= 30'h0;
      data_reg  <= 32'h0;
      aerr_reg  <= 1'b0;
      berr_reg  <= 1'b0;
      cnt_reg   <= '0;
      off_reg   <= 2'b00;
      lt_reg    <= LT_LW;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      aerr_reg  <= aerr_next;
      berr_reg  <= berr_next;
      cnt_reg   <= cnt_next;
      off_reg   <= off_next;
      lt_reg    <= lt_next;
    end
  end

  assign dm_req    = req_reg;
  assign dm_addr   = addr_reg;
  assign read_data = data_reg;
  assign AddrErr   = aerr_reg;
  assign BusErr    = berr_reg;
  assign Stall     = stall_c;

endmodule

// File: tb/tb_mem_stage_load_unit.sv
// Directed bench for mem_stage_load_unit with TIMEOUT=4.
module tb_mem_stage_load_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic [2:0]  LoadType;
  logic [31:0] Addr;
  logic        dm_req;
  logic [29:0] dm_addr;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] read_data;
  logic        Stall;
  logic        AddrErr;
  logic        BusErr;

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_stage_load_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .LoadType  (LoadType),
    .Addr      (Addr),
    .dm_req    (dm_req),
    .dm_addr   (dm_addr),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .read_data (read_data),
    .Stall     (Stall),
    .AddrErr   (AddrErr),
    .BusErr    (BusErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One aligned load; memory acks after 'waits' empty WAIT cycles.
  task automatic do_load(input string tag, input logic [2:0] lt, input logic [31:0] a,
                         input int waits, input logic [31:0] word,
                         input logic [31:0] exp_data);
    int stall_cycles;
    stall_cycles = 0;
    MemRead = 1'b1; LoadType = lt; Addr = a; dm_ack = 1'b0;
    #1;
    if (Stall) stall_cycles++;
    check({tag, " req_before_issue"}, {31'h0, dm_req}, 32'h0);
    tick();
    check({tag, " dm_addr"}, {2'b00, dm_addr}, {2'b00, a[31:2]});
    for (int i = 0; i < waits; i++) begin
      #1;
      if (Stall) stall_cycles++;
      check({tag, " req_held"}, {31'h0, dm_req}, 32'h1);
      tick();
    end
    dm_ack = 1'b1; dm_rdata = word;
    #1;
    if (Stall) stall_cycles++;
    tick();
    dm_ack = 1'b0; dm_rdata = 32'hDEAD_BEEF;
    #1;
    check({tag, " stall_in_done"}, {31'h0, Stall}, 32'h0);
    check({tag, " read_data"}, read_data, exp_data);
    check({tag, " req_dropped"}, {31'h0, dm_req}, 32'h0);
    check({tag, " buserr"}, {31'h0, BusErr}, 32'h0);
    check({tag, " stall_cycles"}, stall_cycles, waits + 2);
    tick();
    MemRead = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; LoadType = 3'b000; Addr = 32'h0;
    dm_ack = 1'b0; dm_rdata = 32'h0;
    #12;
    check("reset dm_req", {31'h0, dm_req}, 32'h0);
    check("reset dm_addr", {2'b00, dm_addr}, 32'h0);
    check("reset read_data", read_data, 32'h0);
    check("reset errs", {30'h0, AddrErr, BusErr}, 32'h0);
    check("reset stall", {31'h0, Stall}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    do_load("lw 0x100", 3'b000, 32'h100, 0, 32'h8765_4321, 32'h8765_4321);
    check("lw dm_addr 0x40", {2'b00, dm_addr}, 32'h40);
    do_load("lb 0x103", 3'b011, 32'h103, 3, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu 0x103", 3'b100, 32'h103, 3, 32'h80FF_0000, 32'h0000_0080);
    do_load("lh 0x202", 3'b001, 32'h202, 1, 32'h8001_1234, 32'hFFFF_8001);
    do_load("lhu 0x200", 3'b010, 32'h200, 0, 32'h8001_1234, 32'h0000_1234);
    do_load("lb 0x001", 3'b011, 32'h001, 0, 32'h1122_7F44, 32'h0000_007F);
    do_load("lt111 0x10", 3'b111, 32'h10, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Misaligned LW: pulse AddrErr, no request, data held.
    MemRead = 1'b1; LoadType = 3'b000; Addr = 32'h102;
    #1;
    check("mis stall", {31'h0, Stall}, 32'h0);
    tick();
    MemRead = 1'b0;
    #1;
    check("mis addrerr", {31'h0, AddrErr}, 32'h1);
    check("mis no req", {31'h0, dm_req}, 32'h0);
    check("mis data held", read_data, 32'hCAFE_F00D);
    tick();
    check("mis addrerr pulse end", {31'h0, AddrErr}, 32'h0);
    check("mis no req later", {31'h0, dm_req}, 32'h0);

    // Misaligned LH (odd address).
    MemRead = 1'b1; LoadType = 3'b001; Addr = 32'h201;
    tick();
    MemRead = 1'b0;
    #1;
    check("mis lh addrerr", {31'h0, AddrErr}, 32'h1);
    tick();

    // Timeout: no ack for 4 WAIT cycles.
    MemRead = 1'b1; LoadType = 3'b000; Addr = 32'h300;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to waiting", {30'h0, dm_req, BusErr}, 32'h2);
      tick();
    end
    #1;
    check("to buserr", {31'h0, BusErr}, 32'h1);
    check("to read_data", read_data, 32'h0);
    check("to req low", {31'h0, dm_req}, 32'h0);
    check("to stall done", {31'h0, Stall}, 32'h0);
    tick();
    MemRead = 1'b0;
    #1;
    check("to buserr pulse end", {31'h0, BusErr}, 32'h0);

    // Ack on the 4th WAIT cycle beats the timeout.
    do_load("ack@4", 3'b000, 32'h304, 3, 32'h1357_9BDF, 32'h1357_9BDF);

    // Reset during WAIT, then a stray ack.
    MemRead = 1'b1; LoadType = 3'b000; Addr = 32'h400;
    tick();
    check("rst pre req", {31'h0, dm_req}, 32'h1);
    reset = 1'b1; MemRead = 1'b0;
    #1;
    check("rst req drop", {31'h0, dm_req}, 32'h0);
    check("rst read_data", read_data, 32'h0);
    check("rst dm_addr", {2'b00, dm_addr}, 32'h0);
    check("rst stall", {31'h0, Stall}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    tick();
    dm_ack = 1'b0;
    #1;
    check("stray ack data", read_data, 32'h0);
    check("stray ack req", {31'h0, dm_req}, 32'h0);
    do_load("post rst", 3'b001, 32'h502, 0, 32'h7ABC_0000, 32'h0000_7ABC);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Global guard against a hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
